// File: rtl/latch_bank_wr_ctrl_pkg.sv
// Shared definitions for the latch bank write controller: FSM state
// encoding and a constant-evaluable clog2 used to size ports and counters.
package latch_bank_wr_ctrl_pkg;

  // Write sequence phases; every write walks IDLE->SETUP->PULSE->HOLD->DONE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } lbc_state_e;

  // Ceiling log2, returns 0 for values <= 1. Callers clamp to >= 1 bit.
  function automatic int lbc_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/latch_bank_wr_ctrl_rr_arbiter.sv
// Round-robin arbiter. The grant is purely combinational from the request
// vector and the priority pointer; the pointer register lives here and moves
// to one past the winner whenever the owner accepts the grant.
module latch_bank_wr_ctrl_rr_arbiter
  import latch_bank_wr_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = (lbc_clog2(NREQ) < 1) ? 1 : lbc_clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_req
);

  logic [IW-1:0] ptr;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          found;

  // Scan from the pointer upwards with wrap; the first asserted request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    any_req = |req;
  end

  // Pointer moves past the winner so it ranks lowest on the next round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer for a bank of level-enabled D latches. One write at a time:
// the winning requester's word is placed on lat_d, then the addressed enable
// is pulsed with fixed setup/pulse/hold margins, then ack closes the write.
//
// Handshake: a requester raises req with addr/wdata and holds all three stable
// until it sees its one-cycle ack. Arbitration happens only in IDLE; after the
// capture edge req/addr/wdata are ignored, and a write that has been captured
// always completes with an ack even if req drops.
module latch_bank_wr_ctrl
  import latch_bank_wr_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int AW        = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  localparam int IW   = (lbc_clog2(NREQ) < 1) ? 1 : lbc_clog2(NREQ),
  localparam int NENT = 1 << AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    ack,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic [DW-1:0]      lat_d,
  output logic [NENT-1:0]    lat_le
);

  localparam int MAXC = (SETUP_CYC > PULSE_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CW   = (lbc_clog2(MAXC) < 1) ? 1 : lbc_clog2(MAXC);

  // A zero-length phase would let data and enable change on the same edge.
  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
    $error("latch_bank_wr_ctrl: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
  end

  lbc_state_e      state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [AW-1:0]   addr_q;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            any_req;
  logic            take;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [NENT-1:0] le_d;
  logic [NREQ-1:0] ack_d;
  logic            busy_d;

  assign take = (state == ST_IDLE) && any_req;

  latch_bank_wr_ctrl_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .advance   (take),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  // One-hot AND-OR select of the winning requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr = sel_addr | addr[i*AW +: AW];
        sel_data = sel_data | wdata[i*DW +: DW];
      end
    end
  end

  // State and phase counter registers; reset aborts any write in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Phase sequencing; each timed phase reloads its down-counter on entry.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_d = ST_PULSE;
          cnt_d   = CW'(PULSE_CYC - 1);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they can be registered glitch-free.
  always_comb begin
    le_d   = '0;
    ack_d  = '0;
    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_PULSE) le_d[addr_q] = 1'b1;
    if (state_d == ST_DONE)  ack_d[grant_id] = 1'b1;
  end

  // Output and capture registers; lat_d only moves on the IDLE->SETUP edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_le   <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      lat_d    <= '0;
      addr_q   <= '0;
      grant_id <= '0;
    end else begin
      lat_le <= le_d;
      ack    <= ack_d;
      busy   <= busy_d;
      if (take) begin
        lat_d    <= sel_data;
        addr_q   <= sel_addr;
        grant_id <= arb_idx;
      end
    end
  end

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Bench for latch_bank_wr_ctrl. A cycle-level reference model arbitrates the
// bench's own requests by round-robin and, for each accepted write, lays out
// the expected output timeline from the phase lengths. A monitor compares the
// DUT each cycle, checks the enable invariants, keeps a latch bank model and
// pops the expected-write queue on every ack.
module tb_latch_bank_wr_ctrl;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int AW        = 2;
  localparam int SETUP_CYC = 1;
  localparam int PULSE_CYC = 2;
  localparam int HOLD_CYC  = 1;
  localparam int IW        = 2;
  localparam int NENT      = 4;
  localparam int ACK_OFS   = SETUP_CYC + PULSE_CYC + HOLD_CYC + 1;
  localparam int SPACING   = ACK_OFS + 1;
  localparam int EW        = IW + AW + DW;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    ack;
  logic               busy;
  logic [IW-1:0]      grant_id;
  logic [DW-1:0]      lat_d;
  logic [NENT-1:0]    lat_le;

  latch_bank_wr_ctrl #(
    .NREQ(NREQ), .DW(DW), .AW(AW),
    .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .lat_d    (lat_d),
    .lat_le   (lat_le)
  );

  typedef struct packed {
    logic            busy;
    logic [NENT-1:0] le;
    logic [NREQ-1:0] ack;
    logic [DW-1:0]   d;
    logic            chk_gid;
    logic [IW-1:0]   gid;
  } tl_t;

  tl_t             exp_tl[int];
  logic [EW-1:0]   exp_q[$];
  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;

  int              m_free;
  int              m_ptr;
  logic [DW-1:0]   m_last_data;

  bit              r_active[NREQ];
  bit              r_granted[NREQ];
  bit              r_rereq[NREQ];
  int              r_ack_cyc[NREQ];
  bit              rand_mode;

  logic [DW-1:0]   bank[NENT];
  logic [NENT-1:0] prev_le = '0;
  logic [DW-1:0]   prev_d = '0;
  int              ack_order[$];
  int              ack_cycles[$];
  int              ack_total = 0;

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r_active[i]        = 1'b1;
    req[i]             = 1'b1;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
  endtask

  task automatic to_neg(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk);
  endtask

  // Requester behaviour: finish after ack, optionally disturb inputs after capture
  task automatic bookkeeping();
    for (int i = 0; i < NREQ; i++) begin
      if (r_granted[i] && cyc == r_ack_cyc[i] + 1) begin
        r_granted[i] = 1'b0;
        if (r_rereq[i]) begin
          r_rereq[i]        = 1'b0;
          wdata[i*DW +: DW] = DW'($urandom);
          req[i]            = 1'b1;
        end else begin
          r_active[i] = 1'b0;
          req[i]      = 1'b0;
        end
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r_granted[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            addr[i*AW +: AW]  = AW'($urandom);
            wdata[i*DW +: DW] = DW'($urandom);
          end
          if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
        end else if (!r_active[i] && $urandom_range(0, 2) == 0) begin
          issue(i, AW'($urandom), DW'($urandom));
        end
      end
    end
  endtask

  // Reference model: one cycle of arbitration and timeline scheduling
  task automatic model_cycle();
    tl_t           e;
    int            w;
    int            j;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!rst_n) begin
      for (int k = 1; k <= SPACING + 1; k++) begin
        if (exp_tl.exists(cyc + k)) exp_tl.delete(cyc + k);
      end
      e = '0;
      e.chk_gid = 1'b1;
      exp_tl[cyc + 1] = e;
      exp_q.delete();
      m_ptr       = 0;
      m_last_data = '0;
      m_free      = cyc + 1;
      for (int i = 0; i < NREQ; i++) r_granted[i] = 1'b0;
      return;
    end
    if (!exp_tl.exists(cyc + 1)) begin
      e = '0;
      e.d = m_last_data;
      exp_tl[cyc + 1] = e;
    end
    if (cyc >= m_free && req != '0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (w < 0 && req[j]) w = j;
      end
      a = addr[w*AW +: AW];
      d = wdata[w*DW +: DW];
      exp_q.push_back({IW'(w), a, d});
      for (int t = 1; t <= ACK_OFS; t++) begin
        e = '0;
        e.busy    = 1'b1;
        e.d       = d;
        e.chk_gid = 1'b1;
        e.gid     = IW'(w);
        if (t >= SETUP_CYC + 1 && t <= SETUP_CYC + PULSE_CYC) e.le = NENT'(1) << a;
        if (t == ACK_OFS) e.ack = NREQ'(1) << w;
        exp_tl[cyc + t] = e;
      end
      m_last_data  = d;
      m_free       = cyc + SPACING;
      m_ptr        = (w + 1) % NREQ;
      r_granted[w] = 1'b1;
      r_ack_cyc[w] = cyc + ACK_OFS;
    end
  endtask

  // Driver-side bookkeeping and model, after the directed stimulus of the cycle
  initial begin
    forever begin
      @(posedge clk);
      #2;
      bookkeeping();
      model_cycle();
    end
  end

  // Monitor: timeline compare, invariants, latch bank model, ack scoreboard
  always @(negedge clk) begin
    tl_t           e;
    logic [EW-1:0] x;
    logic [IW-1:0] id;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            ack_idx;
    if (exp_tl.exists(cyc)) begin
      e = exp_tl[cyc];
      exp_tl.delete(cyc);
      tests++;
      if (busy !== e.busy || lat_le !== e.le || ack !== e.ack || lat_d !== e.d ||
          (e.chk_gid && grant_id !== e.gid)) begin
        fails++;
        $display("FAIL timeline cyc=%0d got busy=%b le=%b ack=%b lat_d=%h gid=%0d, expected busy=%b le=%b ack=%b lat_d=%h gid=%0d",
                 cyc, busy, lat_le, ack, lat_d, grant_id, e.busy, e.le, e.ack, e.d, e.gid);
      end
    end
    tests++;
    if ($countones(lat_le) > 1) begin
      fails++;
      $display("FAIL le_onehot cyc=%0d got lat_le=%b, expected at most one bit", cyc, lat_le);
    end
    tests++;
    if (prev_le != '0 && lat_le != '0 && lat_d != prev_d) begin
      fails++;
      $display("FAIL data_stable cyc=%0d got lat_d=%h while LE high, expected %h", cyc, lat_d, prev_d);
    end
    for (int k = 0; k < NENT; k++) begin
      if (lat_le[k]) bank[k] = lat_d;
    end
    if (ack != '0) begin
      tests++;
      ack_total++;
      ack_idx = -1;
      for (int k = 0; k < NREQ; k++) if (ack[k] && ack_idx < 0) ack_idx = k;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack cyc=%0d got ack=%b, expected no ack", cyc, ack);
      end else begin
        x = exp_q.pop_front();
        {id, a, d} = x;
        ack_order.push_back(ack_idx);
        ack_cycles.push_back(cyc);
        if (ack !== (NREQ'(1) << id) || grant_id !== id || bank[a] !== d) begin
          fails++;
          $display("FAIL ack_write cyc=%0d got ack=%b gid=%0d Q[%0d]=%h, expected ack=%b gid=%0d Q=%h",
                   cyc, ack, grant_id, a, bank[a], NREQ'(1) << id, id, d);
        end
      end
    end
    prev_le = lat_le;
    prev_d  = lat_d;
  end

  // Directed sequence followed by random traffic
  initial begin
    int snap;
    rst_n       = 1'b0;
    req         = '0;
    addr        = '0;
    wdata       = '0;
    rand_mode   = 1'b0;
    m_free      = 0;
    m_ptr       = 0;
    m_last_data = '0;
    for (int k = 0; k < NENT; k++) bank[k] = '0;

    // Reset with all requesters asserted, then contention
    for (int i = 0; i < NREQ; i++) issue(i, AW'(NREQ - 1 - i), DW'(17 * (i + 1)));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (28) @(posedge clk);
    #1;
    chk("contention_ack_count", ack_order.size(), 4);
    for (int k = 0; k < ack_order.size() && k < 4; k++) chk("contention_order", ack_order[k], k);
    for (int k = 1; k < ack_cycles.size() && k < 4; k++)
      chk("contention_spacing", ack_cycles[k] - ack_cycles[k-1], SPACING);

    // Single write: requester 2, entry 3, data A5
    issue(2, 2'd3, 8'hA5);
    to_neg(1);
    chk("single_busy_c1", int'(busy), 1);
    chk("single_lat_d_c1", int'(lat_d), 'hA5);
    chk("single_le_c1", int'(lat_le), 0);
    to_neg(1);
    chk("single_le_c2", int'(lat_le), 'b1000);
    to_neg(1);
    chk("single_le_c3", int'(lat_le), 'b1000);
    to_neg(1);
    chk("single_le_c4", int'(lat_le), 0);
    to_neg(1);
    chk("single_ack_c5", int'(ack), 'b0100);
    chk("single_busy_c5", int'(busy), 1);
    to_neg(1);
    chk("single_busy_c6", int'(busy), 0);
    @(posedge clk);
    #1;

    // Fairness: requester 0 re-requests right after its ack while 1 waits
    ack_order.delete();
    issue(0, 2'd0, 8'h5A);
    issue(1, 2'd1, 8'hC3);
    r_rereq[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("fair_ack_count", ack_order.size(), 3);
    if (ack_order.size() == 3) begin
      chk("fair_first", ack_order[0], 0);
      chk("fair_second", ack_order[1], 1);
      chk("fair_third", ack_order[2], 0);
    end

    // Reset in the middle of an enable pulse
    snap = ack_total;
    issue(3, 2'd1, 8'h3C);
    to_neg(2);
    chk("midpulse_le_live", int'(lat_le), 'b0010);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    req[3]      = 1'b0;
    r_active[3] = 1'b0;
    to_neg(1);
    chk("midpulse_le_cleared", int'(lat_le), 0);
    chk("midpulse_ack_clear", int'(ack), 0);
    chk("midpulse_busy_clear", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midpulse_no_ack", ack_total - snap, 0);

    // Random request traffic
    rand_mode = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    rand_mode = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("drain_exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
